// File: rtl/pipe_pkg.sv
// Shared constants for the miniLA inter-stage pipeline registers.
// Stage payload widths, IF/ID field offsets and the canonical NOP encoding.
package pipe_pkg;

    localparam int unsigned IF_ID_W  = 96;
    localparam int unsigned ID_EX_W  = 176;
    localparam int unsigned EX_MEM_W = 104;
    localparam int unsigned MEM_WB_W = 72;

    // IF/ID payload layout: {pc, inst, pc4}
    localparam int unsigned PC_LSB   = 64;
    localparam int unsigned INST_LSB = 32;
    localparam int unsigned PC4_LSB  = 0;

    localparam logic [31:0] LA_NOP = 32'h0340_0000;

    // Skid-mode occupancy encoded as {main_v, skid_v}
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StTwo   = 2'b11
    } skid_state_e;

    function automatic logic [31:0] if_id_inst(input logic [IF_ID_W-1:0] payload);
        return payload[INST_LSB +: 32];
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with flush and an optional skid entry.
// SKID=1 keeps in_ready registered so no combinational path runs out_ready -> in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = IF_ID_W,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_xfer, out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_v_q & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            skid_state_e state;

            assign state    = skid_state_e'({main_v_q, skid_v_q});
            assign in_ready = ~skid_v_q;

            always_comb begin
                main_v_d = main_v_q;
                skid_v_d = skid_v_q;
                main_d   = main_q;
                skid_d   = skid_q;
                unique case (state)
                    StEmpty: begin
                        if (in_xfer) begin
                            main_d   = in_data;
                            main_v_d = 1'b1;
                        end
                    end
                    StOne: begin
                        if (in_xfer && out_xfer) begin
                            main_d = in_data;
                        end else if (in_xfer) begin
                            skid_d   = in_data;
                            skid_v_d = 1'b1;
                        end else if (out_xfer) begin
                            main_v_d = 1'b0;
                        end
                    end
                    StTwo: begin
                        if (out_xfer) begin
                            main_d   = skid_q;
                            skid_v_d = 1'b0;
                        end
                    end
                    default: begin
                        main_v_d = 1'b0;
                        skid_v_d = 1'b0;
                    end
                endcase
                // Flush drops held entries and any same-cycle input; data regs stay put.
                if (flush) begin
                    main_v_d = 1'b0;
                    skid_v_d = 1'b0;
                    main_d   = main_q;
                    skid_d   = skid_q;
                end
            end
        end else begin : g_noskid
            assign in_ready = out_ready | ~main_v_q;

            always_comb begin
                main_v_d = main_v_q;
                main_d   = main_q;
                skid_v_d = 1'b0;
                skid_d   = '0;
                if (flush) begin
                    main_v_d = 1'b0;
                end else if (in_xfer) begin
                    main_d   = in_data;
                    main_v_d = 1'b1;
                end else if (out_xfer) begin
                    main_v_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_q   <= '0;
            skid_q   <= '0;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
        end
    end

    assign out_valid = main_v_q;
    assign out_data  = main_v_q ? main_q : '0;
    assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: scoreboarded SKID=1 instance plus a directed SKID=0 instance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [95:0] in_data, out_data;
    logic [1:0]  occupancy;

    logic        s0_flush, s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready;
    logic [95:0] s0_in_data, s0_out_data;
    logic [1:0]  s0_occ;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [95:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [95:0] prev_data;
    logic        in_pend = 1'b0;
    logic [95:0] pend_data;

    localparam logic [95:0] P0 = 96'h1C000000_02800C05_1C000004;
    localparam logic [95:0] P1 = 96'h1C000004_02800C06_1C000008;
    localparam logic [95:0] PA = 96'hAAAA0000_00000000_0000000A;
    localparam logic [95:0] PB = 96'hBBBB0000_00000000_0000000B;
    localparam logic [95:0] PC = 96'hCCCC0000_00000000_0000000C;
    localparam logic [95:0] PD = 96'hDDDD0000_00000000_0000000D;
    localparam logic [95:0] PE = 96'hEEEE0000_00000000_0000000E;
    localparam logic [95:0] PF = 96'hFFFF0000_00000000_0000000F;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(96), .SKID(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_stage_reg #(.DATA_W(96), .SKID(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (s0_flush),
        .in_valid  (s0_in_valid),
        .in_ready  (s0_in_ready),
        .in_data   (s0_in_data),
        .out_valid (s0_out_valid),
        .out_ready (s0_out_ready),
        .out_data  (s0_out_data),
        .occupancy (s0_occ)
    );

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input monitor: records accepted payloads and polices the upstream hold rule.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pend = 1'b0;
            end else begin
                if (in_pend && !flush)
                    assert (in_valid && in_data == pend_data)
                    else $error("upstream dropped or changed a pending payload");
                if (in_valid && in_ready && !flush) exp_q.push_back(in_data);
                in_pend   = in_valid && !in_ready && !flush;
                pend_data = in_data;
            end
        end
    end

    // Output monitor: pops on every out-transfer, checks masking and stall stability.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", {95'd0, out_valid}, 96'd1);
                    check("stall_data", out_data, prev_data);
                end
                if (!out_valid) check("mask_zero", out_data, 96'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got %0h, expected no output", out_data);
                    end else begin
                        check("sb_data", out_data, exp_q.pop_front());
                    end
                end
                if (flush) exp_q.delete();
                prev_stall = out_valid && !out_ready && !flush;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        logic pend;
        logic acc;
        rst = 1'b1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_in_data = '0;
        #2;
        check("rst_out_valid", {95'd0, out_valid}, 96'd0);
        check("rst_out_data", out_data, 96'd0);
        check("rst_occ", {94'd0, occupancy}, 96'd0);
        check("rst_in_ready", {95'd0, in_ready}, 96'd1);
        check("rst_s0_in_ready", {95'd0, s0_in_ready}, 96'd1);
        tick(); tick();
        rst = 1'b0;

        // Stream two payloads with downstream always ready
        tick();
        in_valid = 1'b1; in_data = P0; out_ready = 1'b1;
        #1 check("t1_in_ready", {95'd0, in_ready}, 96'd1);
        tick();
        check("t1_out_valid", {95'd0, out_valid}, 96'd1);
        check("t1_out_data0", out_data, P0);
        check("t1_occ", {94'd0, occupancy}, 96'd1);
        in_data = P1;
        tick();
        check("t1_out_data1", out_data, P1);
        check("t1_in_ready2", {95'd0, in_ready}, 96'd1);
        in_valid = 1'b0;
        tick();
        check("t1_empty", {94'd0, occupancy}, 96'd0);

        // Stall fill: A, B held; C waits; then drain in order
        out_ready = 1'b0; in_valid = 1'b1; in_data = PA;
        tick();
        check("t2_occ1", {94'd0, occupancy}, 96'd1);
        in_data = PB;
        tick();
        check("t2_occ2", {94'd0, occupancy}, 96'd2);
        check("t2_in_ready0", {95'd0, in_ready}, 96'd0);
        in_data = PC;
        tick();
        check("t2_hold_a", out_data, PA);
        check("t2_c_blocked", {94'd0, occupancy}, 96'd2);
        out_ready = 1'b1;
        #1 check("t2_in_ready_reg", {95'd0, in_ready}, 96'd0);
        tick();
        check("t2_drain_b", out_data, PB);
        check("t2_in_ready1", {95'd0, in_ready}, 96'd1);
        tick();
        check("t2_drain_c", out_data, PC);
        in_valid = 1'b0;
        tick();
        check("t2_empty", {94'd0, occupancy}, 96'd0);

        // Flush with two entries held and D offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = PE;
        tick();
        in_data = PF;
        tick();
        flush = 1'b1; in_data = PD;
        #1 check("t3_occ2", {94'd0, occupancy}, 96'd2);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("t3_out_valid", {95'd0, out_valid}, 96'd0);
        check("t3_out_data", out_data, 96'd0);
        check("t3_occ", {94'd0, occupancy}, 96'd0);
        check("t3_in_ready", {95'd0, in_ready}, 96'd1);
        // Flush in ONE with an acceptable same-cycle input
        in_valid = 1'b1; in_data = PE;
        tick();
        flush = 1'b1; in_data = PD;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        check("t3_d_dropped", {95'd0, out_valid}, 96'd0);

        // Random traffic; scoreboard checks order and stall stability
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            pend = in_valid && !in_ready;
            @(posedge clk);
            #1;
            if (!pend) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = {$urandom(), $urandom(), $urandom()};
            end
            out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
        for (int k = 0; k < 10 && in_valid; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        check("t4_in_done", {95'd0, in_valid}, 96'd0);
        repeat (4) tick();
        check("t4_sb_drained", 96'(exp_q.size()), 96'd0);
        check("t4_occ", {94'd0, occupancy}, 96'd0);

        // SKID=0: combinational in_ready, single entry
        s0_in_valid = 1'b1; s0_in_data = PA; s0_out_ready = 1'b0;
        tick();
        check("t5_valid", {95'd0, s0_out_valid}, 96'd1);
        check("t5_data_a", s0_out_data, PA);
        check("t5_in_ready0", {95'd0, s0_in_ready}, 96'd0);
        s0_out_ready = 1'b1; s0_in_data = PB;
        #1 check("t5_in_ready_comb", {95'd0, s0_in_ready}, 96'd1);
        tick();
        check("t5_replace", s0_out_data, PB);
        check("t5_occ1", {94'd0, s0_occ}, 96'd1);
        s0_out_ready = 1'b0; s0_in_data = PC;
        tick();
        check("t5_hold", s0_out_data, PB);
        check("t5_occ_max", {94'd0, s0_occ}, 96'd1);
        s0_in_valid = 1'b0; s0_out_ready = 1'b1;
        tick();
        check("t5_empty", {95'd0, s0_out_valid}, 96'd0);
        check("t5_mask", s0_out_data, 96'd0);

        // Async reset mid-cycle with two entries held
        out_ready = 1'b0; in_valid = 1'b1; in_data = PA;
        tick();
        in_data = PB;
        tick();
        in_valid = 1'b0;
        #1 check("t6_occ2", {94'd0, occupancy}, 96'd2);
        #1 rst = 1'b1;
        #1;
        check("t6_out_valid", {95'd0, out_valid}, 96'd0);
        check("t6_out_data", out_data, 96'd0);
        check("t6_occ", {94'd0, occupancy}, 96'd0);
        check("t6_in_ready", {95'd0, in_ready}, 96'd1);
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
